// File: rtl/serial_slave_burst.sv
// Serial bus slave with burst transfers: decodes ID/address/length, strobes writes, stalls reads.
// Optional per-word even parity is enabled by defining SERIAL_SLAVE_PARITY_EN.
module serial_slave_burst #(
  parameter int                  ID_WIDTH      = 2,
  parameter logic [ID_WIDTH-1:0] SELF_ID       = 2'b11,
  parameter int                  ADDRESS_WIDTH = 15,
  parameter int                  DATA_WIDTH    = 8,
  parameter int                  BURST_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     module_dv,
  input  logic [DATA_WIDTH-1:0]    data_in_parellel,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy,
  output logic                     write_en_internal,
  output logic                     read_en_internal,
  output logic [DATA_WIDTH-1:0]    data_out_parellel,
  output logic [ADDRESS_WIDTH-1:0] addr_buff,
  output logic                     parity_err
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WORD_BITS = DATA_WIDTH + PAR_BITS;
  localparam int SH_A  = (ADDRESS_WIDTH > WORD_BITS) ? ADDRESS_WIDTH : WORD_BITS;
  localparam int SH_B  = (ID_WIDTH > BURST_WIDTH) ? ID_WIDTH : BURST_WIDTH;
  localparam int SH_W  = (SH_A > SH_B) ? SH_A : SH_B;
  localparam int CNT_W = $clog2(SH_W + 2);

  localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_WIDTH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(BURST_WIDTH - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(WORD_BITS);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_SKIP, S_ADDR, S_LEN, S_WSTART, S_WDATA, S_RD_REQ, S_RD_SHIFT
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SH_W-1:0]          shift_q, shift_d;
  logic [ADDRESS_WIDTH-1:0] addr_buff_q, addr_buff_d;
  logic [BURST_WIDTH-1:0]   words_left_q, words_left_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     write_en_q, write_en_d;
  logic                     inc_pend_q, inc_pend_d;
`ifdef SERIAL_SLAVE_PARITY_EN
  logic                     parity_err_q, parity_err_d;
  logic                     rd_par_q, rd_par_d;
`endif

  logic serial_in;
  logic serial_out;
  logic wr_par_ok;

  assign serial_in = data_bus_serial;

  always_comb begin
    // NOTE: every signal gets its default here so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    shift_d      = {shift_q[SH_W-2:0], serial_in};
    addr_buff_d  = addr_buff_q;
    words_left_d = words_left_q;
    data_out_d   = data_out_q;
    rd_data_d    = rd_data_q;
    write_en_d   = 1'b0;
    inc_pend_d   = 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
    parity_err_d = parity_err_q;
    rd_par_d     = rd_par_q;
    wr_par_ok    = ~^shift_d[WORD_BITS-1:0];
`else
    wr_par_ok    = 1'b1;
`endif

    // The address step of a finished write word lands one cycle after its strobe.
    if (inc_pend_q) addr_buff_d = addr_buff_q + ADDRESS_WIDTH'(1);

    if (state_q != S_IDLE && !bus_util) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (bus_util && !serial_in) state_d = S_ID;
        end
        S_ID: begin
          if (cnt_q == ID_LAST) begin
            cnt_d   = '0;
            state_d = (shift_d[ID_WIDTH-1:0] == SELF_ID) ? S_ADDR : S_SKIP;
          end
        end
        S_SKIP: cnt_d = '0;
        S_ADDR: begin
          if (cnt_q == ADDR_LAST) begin
            cnt_d       = '0;
            addr_buff_d = shift_d[ADDRESS_WIDTH-1:0];
            state_d     = S_LEN;
          end
        end
        S_LEN: begin
          if (cnt_q == LEN_LAST) begin
            cnt_d        = '0;
            words_left_d = shift_d[BURST_WIDTH-1:0];
            state_d      = rd_wrt ? S_RD_REQ : S_WSTART;
          end
        end
        S_WSTART: begin
          cnt_d = '0;
          if (!serial_in) state_d = S_WDATA;
        end
        S_WDATA: begin
          if (cnt_q == WR_LAST) begin
            cnt_d      = '0;
            data_out_d = shift_d[WORD_BITS-1 -: DATA_WIDTH];
            write_en_d = wr_par_ok;
            inc_pend_d = 1'b1;
`ifdef SERIAL_SLAVE_PARITY_EN
            if (!wr_par_ok) parity_err_d = 1'b1;
`endif
            if (words_left_q == '0) begin
              state_d = S_IDLE;
            end else begin
              words_left_d = words_left_q - BURST_WIDTH'(1);
              state_d      = S_WSTART;
            end
          end
        end
        S_RD_REQ: begin
          cnt_d = '0;
          if (module_dv) begin
            rd_data_d = data_in_parellel;
`ifdef SERIAL_SLAVE_PARITY_EN
            rd_par_d  = ^data_in_parellel;
`endif
            state_d   = S_RD_SHIFT;
          end
        end
        S_RD_SHIFT: begin
          // Count 0 is the start bit; the data register shifts once per data bit sent.
          if (cnt_q != '0) rd_data_d = {rd_data_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == RD_LAST) begin
            cnt_d       = '0;
            addr_buff_d = addr_buff_q + ADDRESS_WIDTH'(1);
            if (words_left_q == '0) begin
              state_d = S_IDLE;
            end else begin
              words_left_d = words_left_q - BURST_WIDTH'(1);
              state_d      = S_RD_REQ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of order.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: all state, including the shift/data registers, is reset so nothing powers up as X.
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      addr_buff_q  <= '0;
      words_left_q <= '0;
      data_out_q   <= '0;
      rd_data_q    <= '0;
      write_en_q   <= 1'b0;
      inc_pend_q   <= 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
      parity_err_q <= 1'b0;
      rd_par_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      addr_buff_q  <= addr_buff_d;
      words_left_q <= words_left_d;
      data_out_q   <= data_out_d;
      rd_data_q    <= rd_data_d;
      write_en_q   <= write_en_d;
      inc_pend_q   <= inc_pend_d;
`ifdef SERIAL_SLAVE_PARITY_EN
      parity_err_q <= parity_err_d;
      rd_par_q     <= rd_par_d;
`endif
    end
  end

  always_comb begin
    serial_out = rd_data_q[DATA_WIDTH-1];
    if (cnt_q == '0) serial_out = 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
    if (cnt_q == RD_LAST) serial_out = rd_par_q;
`endif
  end

  assign write_en_internal = write_en_q;
  assign data_out_parellel = data_out_q;
  assign addr_buff         = addr_buff_q;
  assign read_en_internal  = (state_q == S_RD_REQ);
  assign slave_busy        = (state_q == S_RD_REQ) ? 1'b1 : 1'bz;
  assign data_bus_serial   = (state_q == S_RD_SHIFT) ? serial_out : 1'bz;
`ifdef SERIAL_SLAVE_PARITY_EN
  assign parity_err        = parity_err_q;
`else
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_slave_burst.sv
// Bench for serial_slave_burst: directed frames plus random bursts against a transaction-level model.
// Honors SERIAL_SLAVE_PARITY_EN the same way as the design.
module tb_serial_slave_burst;

  localparam logic [1:0] SELF = 2'b11;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_wrt = 1'b0;
  logic        bus_util = 1'b0;
  logic        module_dv = 1'b0;
  logic [7:0]  data_in_parellel = '0;
  logic        m_oe = 1'b0;
  logic        m_bit = 1'b1;
  wire         data_bus_serial;
  wire         slave_busy;
  logic        write_en_internal;
  logic        read_en_internal;
  logic [7:0]  data_out_parellel;
  logic [14:0] addr_buff;
  logic        parity_err;

  int total = 0;
  int bad = 0;
  logic [14:0] exp_addr = '0;
  logic [22:0] wlog[$];

  pullup (data_bus_serial);
  pulldown (slave_busy);
  assign data_bus_serial = m_oe ? m_bit : 1'bz;

  always #5 clk = ~clk;

  serial_slave_burst dut (
    .clk(clk), .rstn(rstn), .rd_wrt(rd_wrt), .bus_util(bus_util),
    .module_dv(module_dv), .data_in_parellel(data_in_parellel),
    .data_bus_serial(data_bus_serial), .slave_busy(slave_busy),
    .write_en_internal(write_en_internal), .read_en_internal(read_en_internal),
    .data_out_parellel(data_out_parellel), .addr_buff(addr_buff), .parity_err(parity_err)
  );

  always @(negedge clk) if (write_en_internal === 1'b1) wlog.push_back({addr_buff, data_out_parellel});

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b);
    m_oe = 1'b1; m_bit = b;
    @(negedge clk);
  endtask

  task automatic send_header(input logic [1:0] id, input logic [14:0] a, input logic [1:0] len, input logic rw);
    bus_util = 1'b1; rd_wrt = rw;
    send_bit(1'b0);
    for (int i = 1; i >= 0; i--) send_bit(id[i]);
    for (int i = 14; i >= 0; i--) send_bit(a[i]);
    for (int i = 1; i >= 0; i--) send_bit(len[i]);
  endtask

  task automatic send_word(input logic [7:0] d, input logic par_flip);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    if (PB == 1) send_bit((^d) ^ par_flip);
  endtask

  task automatic end_frame();
    m_oe = 1'b0; bus_util = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [1:0] len, input logic [7:0] d [4], input int max_gap);
    logic [14:0] wa;
    wlog.delete();
    send_header(SELF, a, len, 1'b0);
    for (int w = 0; w <= int'(len); w++) begin
      repeat ($urandom_range(0, max_gap)) send_bit(1'b1);
      send_word(d[w], 1'b0);
      wa = a + 15'(w);
      total++; if (write_en_internal !== 1'b1) begin bad++; $display("FAIL wr_strobe w=%0d got=%b exp=1", w, write_en_internal); end
      total++; if (data_out_parellel !== d[w]) begin bad++; $display("FAIL wr_data w=%0d got=%h exp=%h", w, data_out_parellel, d[w]); end
      total++; if (addr_buff !== wa) begin bad++; $display("FAIL wr_addr w=%0d got=%h exp=%h", w, addr_buff, wa); end
    end
    @(negedge clk);
    exp_addr = a + 15'(int'(len) + 1);
    total++; if (write_en_internal !== 1'b0) begin bad++; $display("FAIL wr_strobe_width got=%b exp=0", write_en_internal); end
    total++; if (addr_buff !== exp_addr) begin bad++; $display("FAIL wr_addr_after got=%h exp=%h", addr_buff, exp_addr); end
    end_frame();
    total++; if (wlog.size() != int'(len) + 1) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", wlog.size(), int'(len) + 1); end
    for (int w = 0; w < wlog.size() && w <= int'(len); w++) begin
      total++;
      if (wlog[w] !== {15'(a + 15'(w)), d[w]}) begin bad++; $display("FAIL wr_log w=%0d got=%h exp=%h", w, wlog[w], {15'(a + 15'(w)), d[w]}); end
    end
  endtask

  task automatic do_read(input logic [14:0] a, input logic [1:0] len, input logic [7:0] d [4], input int fixed_wait);
    logic [8:0] got, expw;
    int wt;
    send_header(SELF, a, len, 1'b1);
    m_oe = 1'b0;
    for (int w = 0; w <= int'(len); w++) begin
      wt = (fixed_wait > 0) ? fixed_wait : int'($urandom_range(1, 6));
      repeat (wt) begin
        total++; if (slave_busy !== 1'b1 || read_en_internal !== 1'b1) begin bad++; $display("FAIL rd_wait w=%0d busy=%b ren=%b exp=1,1", w, slave_busy, read_en_internal); end
        @(negedge clk);
      end
      total++; if (addr_buff !== 15'(a + 15'(w))) begin bad++; $display("FAIL rd_addr w=%0d got=%h exp=%h", w, addr_buff, 15'(a + 15'(w))); end
      module_dv = 1'b1; data_in_parellel = d[w];
      @(negedge clk);
      module_dv = 1'b0; data_in_parellel = 8'($urandom);
      total++; if (data_bus_serial !== 1'b0 || slave_busy !== 1'b0) begin bad++; $display("FAIL rd_start w=%0d serial=%b busy=%b exp=0,0", w, data_bus_serial, slave_busy); end
      got = '0;
      for (int k = 0; k < 8 + PB; k++) begin
        @(negedge clk);
        got = {got[7:0], data_bus_serial};
        module_dv = 1'($urandom_range(0, 1)); data_in_parellel = 8'($urandom);
      end
      module_dv = 1'b0;
      expw = (PB == 1) ? {d[w], ^d[w]} : {1'b0, d[w]};
      total++; if (got !== expw) begin bad++; $display("FAIL rd_word w=%0d got=%h exp=%h", w, got, expw); end
      @(negedge clk);
    end
    exp_addr = a + 15'(int'(len) + 1);
    total++; if (data_bus_serial !== 1'b1 || slave_busy !== 1'b0 || read_en_internal !== 1'b0) begin
      bad++; $display("FAIL rd_release serial=%b busy=%b ren=%b exp=z(1),z(0),0", data_bus_serial, slave_busy, read_en_internal);
    end
    total++; if (addr_buff !== exp_addr) begin bad++; $display("FAIL rd_addr_after got=%h exp=%h", addr_buff, exp_addr); end
    end_frame();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (write_en_internal !== 1'b0 || read_en_internal !== 1'b0 || parity_err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl we=%b re=%b perr=%b exp=0,0,0", write_en_internal, read_en_internal, parity_err);
    end
    total++; if (data_out_parellel !== 8'h00 || addr_buff !== 15'h0) begin bad++; $display("FAIL reset_regs data=%h addr=%h exp=00,0000", data_out_parellel, addr_buff); end
    total++; if (data_bus_serial !== 1'b1 || slave_busy !== 1'b0) begin bad++; $display("FAIL reset_lines serial=%b busy=%b exp=z(1),z(0)", data_bus_serial, slave_busy); end
    rstn = 1'b1;
    @(negedge clk);
    exp_addr = '0;
  endtask

  task automatic test_directed();
    logic [7:0] d [4];
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    do_write(15'h0005, 2'b00, d, 0);
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(15'h7FFE, 2'b11, d, 0);
    d = '{8'h3C, 8'hC3, 8'h00, 8'h00};
    do_read(15'h0010, 2'b01, d, 30);
  endtask

  task automatic test_id_mismatch();
    wlog.delete();
    send_header(2'b10, 15'h1234, 2'b00, 1'b0);
    send_word(8'h5A, 1'b0);
    repeat (3) begin
      total++; if (write_en_internal !== 1'b0 || slave_busy !== 1'b0) begin bad++; $display("FAIL idmis_quiet we=%b busy=%b exp=0,0", write_en_internal, slave_busy); end
      @(negedge clk);
    end
    end_frame();
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL idmis_strobes got=%0d exp=0", wlog.size()); end
    total++; if (addr_buff !== exp_addr) begin bad++; $display("FAIL idmis_addr got=%h exp=%h", addr_buff, exp_addr); end
  endtask

  task automatic test_abort();
    logic [14:0] a;
    a = 15'($urandom);
    wlog.delete();
    send_header(SELF, a, 2'b00, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    end_frame();
    repeat (4) @(negedge clk);
    exp_addr = a;
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL abort_wr_strobes got=%0d exp=0", wlog.size()); end
    total++; if (addr_buff !== exp_addr) begin bad++; $display("FAIL abort_wr_addr got=%h exp=%h", addr_buff, exp_addr); end
    a = 15'($urandom);
    send_header(SELF, a, 2'b01, 1'b1);
    m_oe = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (slave_busy !== 1'b1) begin bad++; $display("FAIL abort_rd_busy_before got=%b exp=1", slave_busy); end
    bus_util = 1'b0;
    @(negedge clk);
    exp_addr = a;
    total++; if (slave_busy !== 1'b0 || read_en_internal !== 1'b0) begin bad++; $display("FAIL abort_rd_release busy=%b ren=%b exp=z(0),0", slave_busy, read_en_internal); end
    module_dv = 1'b1; data_in_parellel = 8'h00;
    @(negedge clk);
    module_dv = 1'b0;
    @(negedge clk);
    total++; if (data_bus_serial !== 1'b1) begin bad++; $display("FAIL abort_rd_dv_ignored serial=%b exp=z(1)", data_bus_serial); end
    total++; if (addr_buff !== exp_addr) begin bad++; $display("FAIL abort_rd_addr got=%h exp=%h", addr_buff, exp_addr); end
  endtask

  task automatic test_strobe_with_drop();
    logic [14:0] a;
    a = 15'($urandom);
    send_header(SELF, a, 2'b00, 1'b0);
    send_word(8'h6B, 1'b0);
    bus_util = 1'b0; m_oe = 1'b0;
    total++; if (write_en_internal !== 1'b1 || data_out_parellel !== 8'h6B) begin
      bad++; $display("FAIL drop_strobe we=%b data=%h exp=1,6b", write_en_internal, data_out_parellel);
    end
    repeat (2) @(negedge clk);
    exp_addr = a + 15'(1);
  endtask

  task automatic test_parity();
    logic [14:0] a;
`ifdef SERIAL_SLAVE_PARITY_EN
    logic [7:0] d [4];
    a = 15'($urandom);
    wlog.delete();
    send_header(SELF, a, 2'b00, 1'b0);
    send_word(8'hA5, 1'b1);
    total++; if (write_en_internal !== 1'b0 || parity_err !== 1'b1) begin bad++; $display("FAIL par_bad we=%b perr=%b exp=0,1", write_en_internal, parity_err); end
    @(negedge clk);
    total++; if (addr_buff !== 15'(a + 15'(1))) begin bad++; $display("FAIL par_addr got=%h exp=%h", addr_buff, 15'(a + 15'(1))); end
    end_frame();
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    do_read(15'h0200, 2'b00, d, 2);
    d = '{8'h81, 8'h00, 8'h00, 8'h00};
    do_write(15'h0300, 2'b00, d, 0);
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_sticky got=%b exp=1", parity_err); end
`else
    a = 15'($urandom);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_tied got=%b exp=0 at %h", parity_err, a); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [14:0] a;
    logic [1:0] len;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      a = (t % 4 == 0) ? 15'(15'h7FFF - 15'($urandom_range(0, 2))) : 15'($urandom);
      len = 2'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(a, len, d, 0);
      else do_write(a, len, d, 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [4];
    d = '{8'hFF, 8'h00, 8'h80, 8'h01};
    do_write(15'h4000, 2'b11, d, 0);
    do_read(15'h4002, 2'b11, d, 1);
    do_write(15'h7FFF, 2'b01, d, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_id_mismatch();
    test_abort();
    test_strobe_with_drop();
    test_parity();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
